// File: rtl/code_entry_if.sv
// Key input and display/status bundle between the keypad chain, the
// code-entry controller and the display driver.
interface code_entry_if;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] disp_digits;
   logic [2:0]  digit_count;
   logic [7:0]  tries;
   logic        unlocked;
   logic        locked_out;
   logic        pass_pulse;
   logic        fail_pulse;

   // Upstream side: presents keys and observes the controller status.
   modport master (
      output key_valid, key_code,
      input  disp_digits, digit_count, tries, unlocked, locked_out,
             pass_pulse, fail_pulse
   );

   // Controller side.
   modport slave (
      input  key_valid, key_code,
      output disp_digits, digit_count, tries, unlocked, locked_out,
             pass_pulse, fail_pulse
   );
endinterface

// File: rtl/code_entry_ctrl.sv
// Keypad code-entry controller: collects four BCD digits, checks them against
// a fixed secret on Enter, holds an unlock window on a match and imposes a
// timed lockout after too many consecutive failures. All outputs registered.
module code_entry_ctrl #(
   parameter logic [15:0] SECRET      = 16'h1234,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned OPEN_CYCLES = 50_000_000,
   parameter int unsigned LOCK_CYCLES = 500_000_000
) (
   input  logic        clk,
   input  logic        RST,
   code_entry_if.slave bus
);

   typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKED} state_t;

   localparam logic [31:0] OPEN_LAST   = 32'(OPEN_CYCLES - 1);
   localparam logic [31:0] LOCK_LAST   = 32'(LOCK_CYCLES - 1);
   localparam logic [8:0]  MAX_TRIES_W = 9'(MAX_TRIES);
   localparam logic [3:0]  KEY_CLEAR   = 4'hA;
   localparam logic [3:0]  KEY_ENTER   = 4'hB;

   state_t      state_reg;
   logic [15:0] digits_reg;
   logic [2:0]  count_reg;
   logic [7:0]  tries_reg;
   logic        unlocked_reg;
   logic        locked_reg;
   logic        pass_reg;
   logic        fail_reg;
   logic [31:0] timer_reg;

   // Failure count after this attempt; nine bits so the lockout compare
   // cannot wrap, and the stored value saturates at 255.
   logic [8:0]  tries_plus;
   logic [7:0]  tries_sat;

   assign tries_plus = {1'b0, tries_reg} + 9'd1;
   assign tries_sat  = (tries_reg == 8'hFF) ? 8'hFF : tries_plus[7:0];

   // Control FSM with all status outputs held in registers.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_reg    <= ENTRY;
         digits_reg   <= 16'h0000;
         count_reg    <= 3'd0;
         tries_reg    <= 8'd0;
         unlocked_reg <= 1'b0;
         locked_reg   <= 1'b0;
         pass_reg     <= 1'b0;
         fail_reg     <= 1'b0;
         timer_reg    <= 32'd0;
      end else begin
         pass_reg <= 1'b0;
         fail_reg <= 1'b0;
         case (state_reg)
            ENTRY: begin
               if (bus.key_valid) begin
                  if (bus.key_code <= 4'd9) begin
                     if (count_reg != 3'd4) begin
                        digits_reg <= {digits_reg[11:0], bus.key_code};
                        count_reg  <= count_reg + 3'd1;
                     end
                  end else if (bus.key_code == KEY_CLEAR) begin
                     digits_reg <= 16'h0000;
                     count_reg  <= 3'd0;
                  end else if (bus.key_code == KEY_ENTER && count_reg == 3'd4) begin
                     state_reg <= CHECK;
                  end
               end
            end
            CHECK: begin
               digits_reg <= 16'h0000;
               count_reg  <= 3'd0;
               timer_reg  <= 32'd0;
               if (digits_reg == SECRET) begin
                  pass_reg     <= 1'b1;
                  tries_reg    <= 8'd0;
                  unlocked_reg <= 1'b1;
                  state_reg    <= OPEN;
               end else begin
                  fail_reg  <= 1'b1;
                  tries_reg <= tries_sat;
                  if (tries_plus >= MAX_TRIES_W) begin
                     locked_reg <= 1'b1;
                     state_reg  <= LOCKED;
                  end else begin
                     state_reg <= ENTRY;
                  end
               end
            end
            OPEN: begin
               if (timer_reg == OPEN_LAST) begin
                  unlocked_reg <= 1'b0;
                  timer_reg    <= 32'd0;
                  state_reg    <= ENTRY;
               end else begin
                  timer_reg <= timer_reg + 32'd1;
               end
            end
            LOCKED: begin
               if (timer_reg == LOCK_LAST) begin
                  locked_reg <= 1'b0;
                  tries_reg  <= 8'd0;
                  timer_reg  <= 32'd0;
                  state_reg  <= ENTRY;
               end else begin
                  timer_reg <= timer_reg + 32'd1;
               end
            end
            default: state_reg <= ENTRY;
         endcase
      end
   end

   assign bus.disp_digits = digits_reg;
   assign bus.digit_count = count_reg;
   assign bus.tries       = tries_reg;
   assign bus.unlocked    = unlocked_reg;
   assign bus.locked_out  = locked_reg;
   assign bus.pass_pulse  = pass_reg;
   assign bus.fail_pulse  = fail_reg;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Bench for code_entry_ctrl: directed key sequences from the test plan plus
// random key traffic, checked by a scoreboard fed from a behavioural model.
module tb_code_entry_ctrl;

   localparam int OPEN_N = 10;
   localparam int LOCK_N = 20;
   localparam int MAXT   = 3;

   logic clk = 1'b0;
   logic RST = 1'b0;
   always #5 clk = ~clk;

   code_entry_if bus ();

   code_entry_ctrl #(
      .SECRET      (16'h1234),
      .MAX_TRIES   (MAXT),
      .OPEN_CYCLES (OPEN_N),
      .LOCK_CYCLES (LOCK_N)
   ) dut (
      .clk (clk),
      .RST (RST),
      .bus (bus)
   );

   // Edge counter: after posedge number n, cyc == n.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {int edge_n; logic is_pass; int tries;} ev_t;
   typedef struct {int edge_n; logic [15:0] disp; int cnt; int tries;} st_t;

   ev_t ev_q[$];
   st_t st_q[$];

   // Behavioural model state
   int digits[$];
   int m_tries    = 0;
   int busy_until = 0;
   int ambig      = -1;
   int open_lo = 1, open_hi = 0;
   int lock_lo = 1, lock_hi = 0;
   bit mon_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] disp_val();
      logic [15:0] v;
      v = 16'h0;
      foreach (digits[i]) v = {v[11:0], 4'(digits[i])};
      return v;
   endfunction

   // Predict the effect of a key sampled at edge e.
   task automatic model_key(input int code, input int e);
      st_t s;
      ev_t v;
      bit  ok;
      if (e <= busy_until) return;
      if (code == 11 && digits.size() == 4) begin
         s = '{e, disp_val(), 4, m_tries};
         st_q.push_back(s);
         ok = (digits[0] == 1 && digits[1] == 2 && digits[2] == 3 && digits[3] == 4);
         digits.delete();
         if (ok) begin
            m_tries    = 0;
            v          = '{e + 1, 1'b1, 0};
            open_lo    = e + 1;
            open_hi    = e + OPEN_N;
            busy_until = e + 1 + OPEN_N;
            ambig      = busy_until;
         end else begin
            m_tries = (m_tries < 255) ? m_tries + 1 : 255;
            v       = '{e + 1, 1'b0, m_tries};
            if (m_tries >= MAXT) begin
               lock_lo    = e + 1;
               lock_hi    = e + LOCK_N;
               busy_until = e + 1 + LOCK_N;
               ambig      = busy_until;
            end else begin
               busy_until = e + 1;
            end
         end
         ev_q.push_back(v);
         s = '{e + 1, 16'h0, 0, v.tries};
         st_q.push_back(s);
         if (m_tries >= MAXT) m_tries = 0;
      end else begin
         if (code <= 9) begin
            if (digits.size() < 4) digits.push_back(code);
         end else if (code == 10) begin
            digits.delete();
         end
         s = '{e, disp_val(), digits.size(), m_tries};
         st_q.push_back(s);
      end
   endtask

   // Present one key for one cycle; called just after a rising edge.
   task automatic press(input logic [3:0] code);
      int e;
      e = cyc + 1;
      if (e == ambig) begin
         bus.key_valid = 1'b0;
         @(posedge clk); #1;
         e = cyc + 1;
      end
      bus.key_valid = 1'b1;
      bus.key_code  = code;
      model_key(int'(code), e);
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'($urandom_range(0, 15));
   endtask

   // Press n keys taken from the nibbles of w, most significant first.
   task automatic seq(input logic [47:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) press(w[i*4 +: 4]);
   endtask

   task automatic idle(input int n);
      bus.key_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Asynchronous reset pulse between edges; outputs must clear at once.
   task automatic pulse_reset();
      #1;
      RST = 1'b1;
      ev_q.delete();
      st_q.delete();
      digits.delete();
      m_tries    = 0;
      busy_until = cyc;
      ambig      = -1;
      if (open_hi >= cyc) open_hi = cyc - 1;
      if (lock_hi >= cyc) lock_hi = cyc - 1;
      #1;
      check("rst_disp",     bus.disp_digits, 0);
      check("rst_count",    bus.digit_count, 0);
      check("rst_tries",    bus.tries,       0);
      check("rst_unlocked", bus.unlocked,    0);
      check("rst_locked",   bus.locked_out,  0);
      check("rst_pulses",   {bus.pass_pulse, bus.fail_pulse}, 0);
      RST = 1'b0;
   endtask

   // Monitor: compares DUT outputs with scoreboard expectations on falling edges.
   always @(negedge clk) begin
      st_t s;
      ev_t v;
      if (mon_en && !RST) begin
         check("unlocked",   bus.unlocked,   32'(cyc >= open_lo && cyc <= open_hi));
         check("locked_out", bus.locked_out, 32'(cyc >= lock_lo && cyc <= lock_hi));
         if (st_q.size() > 0 && st_q[0].edge_n <= cyc) begin
            s = st_q.pop_front();
            check("disp_digits", bus.disp_digits, s.disp);
            check("digit_count", bus.digit_count, s.cnt);
            check("tries",       bus.tries,       s.tries);
         end
         if (bus.pass_pulse || bus.fail_pulse) begin
            if (ev_q.size() == 0 || ev_q[0].edge_n != cyc) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse: got pass=%0b fail=%0b want none (cycle %0d)",
                        bus.pass_pulse, bus.fail_pulse, cyc);
            end else begin
               v = ev_q.pop_front();
               check("pulse_pass",  bus.pass_pulse, v.is_pass);
               check("pulse_fail",  bus.fail_pulse, !v.is_pass);
               check("pulse_tries", bus.tries,      v.tries);
            end
         end else if (ev_q.size() > 0 && ev_q[0].edge_n <= cyc) begin
            v = ev_q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_pulse: got none want pass=%0b (cycle %0d)", v.is_pass, cyc);
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #500_000;
      $display("FAIL timeout: got no finish want finish (cycle %0d)", cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'h0;
      #1 RST = 1'b1;
      #2;
      check("reset_disp",     bus.disp_digits, 0);
      check("reset_count",    bus.digit_count, 0);
      check("reset_tries",    bus.tries,       0);
      check("reset_unlocked", bus.unlocked,    0);
      check("reset_locked",   bus.locked_out,  0);
      check("reset_pulses",   {bus.pass_pulse, bus.fail_pulse}, 0);
      @(posedge clk); @(posedge clk); #1;
      RST        = 1'b0;
      busy_until = cyc;
      mon_en     = 1'b1;

      // Correct code, then keys pressed while open are ignored
      seq(48'h1234B, 5);
      seq(48'h5555, 4);
      idle(12);

      // Three failures lead to lockout; keys during lockout do nothing
      seq(48'h5678B, 5);
      seq(48'h5678B, 5);
      seq(48'h5678B, 5);
      seq(48'h1234B, 5);
      idle(LOCK_N + 3);

      // Short entry ignored on Enter, fifth digit ignored, then clear
      seq(48'h12B, 3);
      seq(48'h99, 2);
      seq(48'h7, 1);
      idle(2);
      seq(48'hA, 1);

      // Clear mid-entry with ignored codes interleaved
      seq(48'h12A1C2D3E4FB, 12);
      idle(OPEN_N + 3);

      // Two failures, a pass resets tries, a further failure gives tries=1
      seq(48'h5678B, 5);
      seq(48'h5678B, 5);
      seq(48'h1234B, 5);
      idle(OPEN_N + 3);
      seq(48'h5678B, 5);
      idle(3);

      // Reset four cycles into OPEN, then a normal pass
      seq(48'h1234B, 5);
      idle(4);
      pulse_reset();
      seq(48'h1234B, 5);
      idle(OPEN_N + 3);

      // Reset during CHECK: no pulse may appear
      seq(48'h1234B, 5);
      pulse_reset();
      idle(3);

      // Reset during LOCKED
      seq(48'h9999B, 5);
      seq(48'h9999B, 5);
      seq(48'h9999B, 5);
      idle(5);
      pulse_reset();
      idle(2);

      // Random traffic
      repeat (250) begin
         r = $urandom_range(0, 9);
         if (r < 3) begin
            seq(48'h1234B, 5);
         end else if (r < 5) begin
            for (int i = 0; i < 4; i++) press(4'($urandom_range(0, 9)));
            press(4'hB);
         end else begin
            press(4'($urandom_range(0, 15)));
         end
         idle($urandom_range(0, 2));
      end

      idle(LOCK_N + 5);
      check("events_drained", ev_q.size(), 0);
      check("status_drained", st_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/code_entry_ctrl.md
# code_entry_ctrl

Keypad code-entry controller that sits directly downstream of the keypad scan/debounce/one-hot-to-binary chain and upstream of the digit display driver. It consumes one debounced key code per press, accumulates a 4-digit entry, checks it against a fixed secret on Enter, and counts failed attempts. It enforces a timed lockout after too many failures. It drives the entered digits and the try count to the display.

## Interface
- SECRET, 16'h1234, four BCD digits, most significant digit entered first
- MAX_TRIES, 3, failed attempts that trigger lockout (1..255)
- OPEN_CYCLES, 50_000_000, clock cycles `unlocked` is held after a match (>=1)
- LOCK_CYCLES, 500_000_000, clock cycles of lockout (>=1)

- clk  input  1  system clock (50 MHz)
- RST  input  1  asynchronous, active-high reset
- key_valid  input  1  one-cycle strobe, one per debounced key press
- key_code  input  4  key value: 0x0–0x9 digit, 0xA clear, 0xB enter, 0xC–0xF ignored
- disp_digits  output  16  entered digits as 4 BCD nibbles, newest in [3:0]
- digit_count  output  3  number of digits entered (0..4)
- tries  output  8  failed attempts since the last match or lockout expiry
- unlocked  output  1  high while in OPEN
- locked_out  output  1  high while in LOCKED
- pass_pulse  output  1  one-cycle pulse on a successful check
- fail_pulse  output  1  one-cycle pulse on a failed check

## Operation
- States: ENTRY, CHECK, OPEN, LOCKED. All outputs are registered.
- Reset (asynchronous, effective immediately): state ENTRY; disp_digits=0, digit_count=0, tries=0; unlocked, locked_out, pass_pulse and fail_pulse all 0; timer=0.
- ENTRY, on key_valid:
  - Digit with digit_count<4: disp_digits <= {disp_digits[11:0], key_code}; digit_count+1.
  - Digit with digit_count==4: ignored, no change.
  - 0xA: disp_digits=0, digit_count=0.
  - 0xB with digit_count==4: next state CHECK.
  - 0xB with digit_count<4: ignored.
  - 0xC–0xF: ignored.
- CHECK lasts exactly one cycle. It compares disp_digits with SECRET. It clears disp_digits and digit_count on both match and mismatch.
  - Match: pass_pulse=1, tries=0, unlocked=1, timer=0, next state OPEN.
  - Mismatch: fail_pulse=1, tries=tries+1 (saturates at 255).
    - If tries+1 >= MAX_TRIES: locked_out=1, timer=0, next state LOCKED.
    - Otherwise: next state ENTRY.
- OPEN: the timer counts each cycle. When timer==OPEN_CYCLES-1, unlocked=0 and next state is ENTRY.
- LOCKED: the timer counts each cycle. When timer==LOCK_CYCLES-1, locked_out=0, tries=0, and next state is ENTRY.
- key_valid is ignored in CHECK, OPEN and LOCKED. Key presses are not queued.
- Timer is 32 bits wide and unsigned. It is only active in OPEN and LOCKED.
- key_code is only sampled when key_valid=1.

## Timing
- Digit or clear strobe sampled at edge n: disp_digits and digit_count are updated after edge n (latency 1).
- Enter strobe sampled at edge n: state becomes CHECK after edge n. pass_pulse or fail_pulse is high for exactly the cycle after edge n+1. tries, unlocked and locked_out change at that same edge.
- unlocked stays high for exactly OPEN_CYCLES cycles.
- locked_out stays high for exactly LOCK_CYCLES cycles.
- The first key_valid accepted after OPEN or LOCKED is one sampled on or after the edge where state returns to ENTRY.
- Back-to-back key_valid strobes on consecutive cycles are each processed in ENTRY.
- RST asserted mid-CHECK, mid-OPEN or mid-LOCKED returns all outputs to their reset values. No pulse is emitted.

## Test plan
Simulation parameters: SECRET=16'h1234, MAX_TRIES=3, OPEN_CYCLES=10, LOCK_CYCLES=20.
- Keys 1,2,3,4,B -> disp_digits 16'h1234 then 0; one pass_pulse two edges after B; unlocked high exactly 10 cycles; tries=0.
- Keys 5,6,7,8,B three times -> fail_pulse each time; tries 1,2,3; after the third failure locked_out high exactly 20 cycles; keys pressed during lockout have no effect; tries=0 on exit.
- Keys 1,2,B -> ignored (digit_count=2, no pulse). Then keys 9,9 -> digit_count=4; a fifth digit 7 -> ignored; disp_digits=16'h1299.
- Keys 1,2,A,1,2,3,4,B -> clear empties the entry; pass_pulse; keys C–F interleaved anywhere cause no change.
- Two failed attempts, then 1,2,3,4,B -> pass; tries resets to 0. A further failed attempt gives tries=1, not lockout.
- RST pulsed during OPEN at cycle 4 -> unlocked=0 immediately, state ENTRY; a following 1,2,3,4,B passes normally.
